// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer: diff = a - b - bin, one shared full-subtractor cell, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Full-subtractor cell: returns {borrow_out, difference_bit}
    function automatic logic [1:0] fsub_cell(input logic ai, input logic bi, input logic bri);
        logic d;
        logic bo;
        d  = ai ^ bi ^ bri;
        bo = (~ai & bi) | (~ai & bri) | (bi & bri);
        return {bo, d};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SUB_OVF_EN
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       cell_s;
    logic [WIDTH-1:0] res_shift_s;

    // Bit cell on the current LSBs and the result word with the new bit entering at the MSB
    always_comb begin
        cell_s                   = fsub_cell(a_q[0], b_q[0], br_q);
        res_shift_s              = res_q >> 1;
        res_shift_s[WIDTH-1]     = cell_s[0];
    end

    // Next-state logic for the sequencer and its datapath registers
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SUB_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            // DONE accepts a new request exactly like IDLE so back-to-back ops have no dead cycle
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
`ifdef SUB_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_s[1];
                res_d = res_shift_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    diff_d  = res_shift_s;
                    bout_d  = cell_s[1];
`ifdef SUB_OVF_EN
                    ovf_d   = (am_q != bm_q) && (res_shift_s[WIDTH-1] != am_q);
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SUB_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0;
    logic [7:0] b8 = 8'd0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;
`ifdef SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    exp_t       q8[$];
    exp_t       q1[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         nw;
    logic [7:0] last_diff = 8'd0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8),
`ifdef SUB_OVF_EN
        .ovf(ovf8),
`endif
        .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1),
`ifdef SUB_OVF_EN
        .ovf(ovf1),
`endif
        .bout(bout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e.diff});
                chk("bout8", {31'd0, bout8}, {31'd0, e.bout});
                chk("done8_cycle", cyc, e.cyc);
`ifdef SUB_OVF_EN
                chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Monitor for the 1-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("diff1", {31'd0, diff1}, {31'd0, e.diff[0]});
                chk("bout1", {31'd0, bout1}, {31'd0, e.bout});
                chk("done1_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                           input logic [7:0] ediff, input logic ebout, input logic eovf,
                           input logic scramble);
        int n;
        @(negedge clk);
        a8 = ai; b8 = bi; bin8 = bini; start8 = 1'b1;
        q8.push_back('{ediff, ebout, eovf, cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 === 1'b1 && n < 40) begin
            n++;
            if (n == 2 && scramble) begin
                a8 = ~ai; b8 = ~bi; bin8 = ~bini;
            end
            if (n == 4) chk("diff_hold_run", {24'd0, diff8}, {24'd0, last_diff});
            @(negedge clk);
        end
        chk("busy_cycles", n, 32'd8);
        chk("done_pulse_hi", {31'd0, done8}, 32'd1);
        last_diff = ediff;
        @(negedge clk);
        chk("done_pulse_lo", {31'd0, done8}, 32'd0);
    endtask

    task automatic run_op1(input logic ai, input logic bi, input logic bini,
                           input logic ediff, input logic ebout);
        @(negedge clk);
        a1 = ai; b1 = bi; bin1 = bini; start1 = 1'b1;
        q1.push_back('{{7'd0, ediff}, ebout, 1'b0, cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
        chk("busy1_run", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        chk("done1_hi", {31'd0, done1}, 32'd1);
        chk("busy1_idle", {31'd0, busy1}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_bout", {31'd0, bout8}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, 1'b0);
        run_op8(8'd5, 8'd9, 1'b0, 8'd252, 1'b1, 1'b0, 1'b0);
        run_op8(8'd7, 8'd7, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);

        // Back-to-back with start held high, extra start pulses during RUN
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{8'd199, 1'b0, 1'b0, cyc + 9});
        nw = 0;
        while (done8 !== 1'b1 && nw < 40) begin
            @(negedge clk);
            nw++;
        end
        chk("b2b_first_latency", nw, 32'd9);
        a8 = 8'd50; b8 = 8'd50;
        q8.push_back('{8'd0, 1'b0, 1'b0, cyc + 9});
        @(negedge clk);
        chk("b2b_no_dead_cycle", {31'd0, busy8}, 32'd1);
        start8 = 1'b0;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0; a8 = 8'hFF;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        nw = 0;
        while (done8 !== 1'b1 && nw < 40) begin
            @(negedge clk);
            nw++;
        end
        chk("b2b_second_seen", {31'd0, done8}, 32'd1);
        @(negedge clk);
        chk("b2b_idle_after", {31'd0, busy8}, 32'd0);
        last_diff = 8'd0;

        // Operand changes during RUN must not affect the result
        run_op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);

        // Signed overflow vectors
        run_op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_op8(8'd5, 8'd9, 1'b0, 8'd252, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy8}, 32'd0);
        chk("midrst_done", {31'd0, done8}, 32'd0);
        chk("midrst_diff", {24'd0, diff8}, 32'd0);
        chk("midrst_bout", {31'd0, bout8}, 32'd0);
`ifdef SUB_OVF_EN
        chk("midrst_ovf", {31'd0, ovf8}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy8}, 32'd0);
        chk("post_rst_diff", {24'd0, diff8}, 32'd0);

        // WIDTH=1 instance
        run_op1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb8_empty", q8.size(), 32'd0);
        chk("sb1_empty", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtract sequencer. Computes diff = a - b - bin over WIDTH bits using one shared full-subtractor bit cell, one bit per clock, LSB first.
- start/busy/done handshake toward the requesting logic.
- Trades WIDTH cycles of latency for a single bit cell. It is the sequential front end for the combinational full-subtractor datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH)+1, bit counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only in IDLE or DONE.
- a  input  WIDTH  minuend. Captured on the accepted start edge.
- b  input  WIDTH  subtrahend. Captured on the accepted start edge.
- bin  input  1  borrow-in. Captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse. Result valid.
- diff  output  WIDTH  result. Registered and held until the next completion.
- bout  output  1  final borrow-out. Registered and held with diff.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, shift/borrow regs=0.
- States:
  - IDLE: start=1 -> latch a, b into shift regs and bin into borrow reg, cnt=0 -> RUN. Otherwise stay.
  - RUN: busy=1. Each edge:
    - bit cell on LSBs: d = a0^b0^br, br' = (~a0&b0)|(~a0&br)|(b0&br).
    - d shifted into the result shift reg from the MSB side; a, b shift right; cnt++.
    - When cnt == WIDTH-1 on this edge: copy the completed result to diff, br' to bout, -> DONE.
  - DONE: done=1, busy=0 for exactly one cycle.
    - start=1 -> behaves as IDLE acceptance (back-to-back, no dead cycle) -> RUN.
    - Else -> IDLE.
- Latency: start sampled at edge E0 -> done high after edge E0+WIDTH, visible for one clock. diff/bout change on that same edge.
- Throughput: one operation per WIDTH+1 cycles.
- diff/bout stay stable during RUN; they hold the previous result until the new one is committed.
- start while RUN is ignored; no queuing. a/b/bin changes during RUN have no effect.
- Arithmetic: modulo 2^WIDTH. bout=1 iff a < b+bin (unsigned).
- WIDTH=1: RUN lasts one cycle; done follows on the next edge.
- Reset mid-RUN: operation abandoned, all outputs return to reset values immediately, no done pulse.
- No X propagation: all registers are reset.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - Registered alongside diff: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. signed two's-complement overflow of a-b-bin, using the captured operand MSBs.
  - Reset 0, held with diff.
- Undefined: no ovf port, no MSB capture logic.

Test Plan:
- Reset then WIDTH=8, a=100, b=37, bin=0, start pulse -> busy high 8 cycles; done 8 edges after the start edge; diff=63, bout=0.
- a=5, b=9, bin=0 -> diff=252 (8'hFC), bout=1. Then a=7, b=7, bin=1 -> diff=255, bout=1.
- Hold start=1 continuously with a=200, b=1, then a=50, b=50:
  - results 199/bout 0, then 0/bout 0;
  - second done 9 cycles after the first (back-to-back from DONE);
  - start pulses during RUN do not restart the count.
- Change a/b mid-RUN -> result reflects the captured values only. Deassert rst_n at cycle 4 of RUN -> busy, done, diff, bout all 0 asynchronously; no done pulse afterward.
- SUB_OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1. Then a=8'h10, b=8'h01 -> diff=8'h0F, ovf=0.
- WIDTH=1 instance: a=0, b=1, bin=0 -> done on the second edge after start; diff=1, bout=1.
